// File: rtl/prog_load_ctrl_if.sv
// prog_load_ctrl_if: host load stream, instruction-memory write port and CPU control of the boot sequencer
interface prog_load_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 16
);
  logic              start;
  logic [15:0]       word_count;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              abort;
  logic              fm_rst;
  logic              fm_write_en;
  logic [ADDR_W-1:0] fm_write_addr;
  logic [DATA_W-1:0] fm_write_data;
  logic              cpu_reset;
  logic              busy;
  logic              done;
  logic [15:0]       loaded_count;
  logic              err;
  modport master (
    output start, word_count, in_valid, in_data, abort,
    input  in_ready, fm_rst, fm_write_en, fm_write_addr, fm_write_data,
           cpu_reset, busy, done, loaded_count, err
  );
  modport slave (
    input  start, word_count, in_valid, in_data, abort,
    output in_ready, fm_rst, fm_write_en, fm_write_addr, fm_write_data,
           cpu_reset, busy, done, loaded_count, err
  );
endinterface

// File: rtl/prog_load_ctrl.sv
// prog_load_ctrl: boot sequencer that clears instruction memory, streams a program in, then releases the CPU
module prog_load_ctrl #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 'h20,
  parameter int                CLR_CYCLES = 1,
  parameter int                RST_CYCLES = 2,
  parameter int                MAX_WORDS  = 256
) (
  input logic             clk,
  input logic             reset,
  prog_load_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, CPU_RST, RUN} state_t;
  state_t state, state_nx;
  logic [15:0] cnt, idx, tmr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic fm_rst, we, cpu_reset, rdy, busy, done, err;
  logic hs, go, fail, bad, last;
  assign bad  = {16'd0, bus.word_count} > 32'(MAX_WORDS);
  assign last = idx + 16'd1 == cnt;
  always_comb begin
    state_nx = state;
    go = 1'b0;
    hs = 1'b0;
    fail = 1'b0;
    case (state)
      IDLE, RUN: begin
        go = bus.start & ~bad;
        fail = bus.start & bad;
        state_nx = bus.start ? (bad ? IDLE : CLEAR) : state;
      end
      CLEAR: begin
        fail = bus.abort;
        state_nx = bus.abort ? IDLE : tmr != 0 ? CLEAR : cnt == 0 ? CPU_RST : LOAD;
      end
      LOAD: begin
        fail = bus.abort;
        hs = bus.in_valid & rdy & ~bus.abort;
        state_nx = bus.abort ? IDLE : hs & last ? CPU_RST : LOAD;
      end
      CPU_RST: state_nx = tmr == 0 ? RUN : CPU_RST;
      default: state_nx = IDLE;
    endcase
  end
  // Every output is a flop fed from the next state, so all of them change on the same edge.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      tmr <= '0;
      addr <= BASE_ADDR;
      data <= '0;
      fm_rst <= 1'b0;
      we <= 1'b0;
      cpu_reset <= 1'b1;
      rdy <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_nx;
      we <= hs;
      rdy <= state_nx == LOAD;
      busy <= state_nx inside {CLEAR, LOAD, CPU_RST};
      done <= state_nx == RUN;
      fm_rst <= state_nx == CLEAR;
      cpu_reset <= state_nx != RUN;
      tmr <= state_nx == state ? (tmr != 0 ? tmr - 16'd1 : tmr) :
             state_nx == CLEAR ? 16'(CLR_CYCLES - 1) : 16'(RST_CYCLES - 1);
      if (go) begin
        cnt <= bus.word_count;
        idx <= '0;
        err <= 1'b0;
      end
      if (fail) err <= 1'b1;
      if (hs) begin
        data <= bus.in_data;
        addr <= BASE_ADDR + ADDR_W'(idx);
        idx <= idx + 16'd1;
      end
    end
  assign bus.in_ready      = rdy;
  assign bus.fm_rst        = fm_rst;
  assign bus.fm_write_en   = we;
  assign bus.fm_write_addr = addr;
  assign bus.fm_write_data = data;
  assign bus.cpu_reset     = cpu_reset;
  assign bus.busy          = busy;
  assign bus.done          = done;
  assign bus.loaded_count  = idx;
  assign bus.err           = err;
endmodule

// File: tb/tb_prog_load_ctrl.sv
// tb_prog_load_ctrl: directed checks of load, bubbles, count limits, abort, reload and asynchronous reset
module tb_prog_load_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  int wr_cnt = 0;
  logic [31:0] last_addr = '0;
  logic [15:0] last_data = '0;

  prog_load_ctrl_if bus ();
  prog_load_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  always @(posedge clk)
    if (bus.fm_write_en === 1'b1) begin
      wr_cnt <= wr_cnt + 1;
      last_addr <= bus.fm_write_addr;
      last_data <= bus.fm_write_data;
    end

  task automatic do_start(input logic [15:0] wc);
    @(negedge clk);
    bus.start = 1'b1;
    bus.word_count = wc;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic test_reset;
    bus.start = 1'b0;
    bus.word_count = '0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.abort = 1'b0;
    reset = 1'b0;
    #12;
    n_chk++;
    if (bus.cpu_reset !== 1'b1) begin n_fail++; $display("FAIL rst_cpu_reset: got %b want 1", bus.cpu_reset); end
    n_chk++;
    if ({bus.busy, bus.done, bus.err, bus.in_ready, bus.fm_rst, bus.fm_write_en} !== 6'b0) begin
      n_fail++; $display("FAIL rst_flags: got %b want 000000", {bus.busy, bus.done, bus.err, bus.in_ready, bus.fm_rst, bus.fm_write_en});
    end
    n_chk++;
    if (bus.fm_write_addr !== 32'h20 || bus.loaded_count !== 16'd0 || bus.fm_write_data !== 16'd0) begin
      n_fail++; $display("FAIL rst_regs: got addr=%h cnt=%0d data=%h want 20/0/0", bus.fm_write_addr, bus.loaded_count, bus.fm_write_data);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_chk++;
    if (bus.cpu_reset !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_idle_hold: got cpu_reset=%b busy=%b want 1/0", bus.cpu_reset, bus.busy);
    end
  endtask

  task automatic test_normal;
    logic [15:0] w [4];
    w = '{16'h453F, 16'h653F, 16'h8C3D, 16'hBBBF};
    do_start(16'd4);
    bus.in_valid = 1'b1;
    bus.in_data = w[0];
    n_chk++;
    if (bus.fm_rst !== 1'b1 || bus.cpu_reset !== 1'b1 || bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL norm_clear: got fm_rst=%b cpu_reset=%b busy=%b ready=%b want 1/1/1/0", bus.fm_rst, bus.cpu_reset, bus.busy, bus.in_ready);
    end
    @(negedge clk);
    n_chk++;
    if (bus.fm_rst !== 1'b0 || bus.in_ready !== 1'b1 || bus.fm_write_en !== 1'b0) begin
      n_fail++; $display("FAIL norm_load_entry: got fm_rst=%b ready=%b we=%b want 0/1/0", bus.fm_rst, bus.in_ready, bus.fm_write_en);
    end
    for (int i = 0; i < 4; i++) begin
      bus.in_data = w[i];
      @(negedge clk);
      n_chk++;
      if ({bus.fm_write_en, bus.fm_write_addr, bus.fm_write_data, bus.loaded_count} !== {1'b1, 32'h20 + i, w[i], 16'(i + 1)}) begin
        n_fail++;
        $display("FAIL norm_write%0d: got we=%b addr=%h data=%h cnt=%0d want 1/%h/%h/%0d",
                 i, bus.fm_write_en, bus.fm_write_addr, bus.fm_write_data, bus.loaded_count, 32'h20 + i, w[i], i + 1);
      end
    end
    bus.in_valid = 1'b0;
    n_chk++;
    if (bus.in_ready !== 1'b0 || bus.cpu_reset !== 1'b1) begin
      n_fail++; $display("FAIL norm_cpu_rst_entry: got ready=%b cpu_reset=%b want 0/1", bus.in_ready, bus.cpu_reset);
    end
    @(negedge clk);
    n_chk++;
    if (bus.cpu_reset !== 1'b1 || bus.done !== 1'b0 || bus.fm_write_en !== 1'b0) begin
      n_fail++; $display("FAIL norm_cpu_rst_hold: got cpu_reset=%b done=%b we=%b want 1/0/0", bus.cpu_reset, bus.done, bus.fm_write_en);
    end
    @(negedge clk);
    n_chk++;
    if (bus.cpu_reset !== 1'b0 || bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.loaded_count !== 16'd4) begin
      n_fail++; $display("FAIL norm_run: got cpu_reset=%b done=%b busy=%b cnt=%0d want 0/1/0/4", bus.cpu_reset, bus.done, bus.busy, bus.loaded_count);
    end
  endtask

  task automatic test_bubbles;
    logic [4:0] p;
    int k;
    p = 5'b10101;
    k = 0;
    do_start(16'd3);
    n_chk++;
    if (bus.cpu_reset !== 1'b1 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL bub_restart: got cpu_reset=%b done=%b want 1/0", bus.cpu_reset, bus.done);
    end
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = p[c];
      bus.in_data = p[c] ? 16'h1000 + 16'(k) : 16'hDEAD;
      @(negedge clk);
      n_chk++;
      if (bus.fm_write_en !== p[c] || (p[c] && (bus.fm_write_addr !== 32'h20 + k || bus.fm_write_data !== 16'h1000 + 16'(k)))) begin
        n_fail++;
        $display("FAIL bub_cycle%0d: got we=%b addr=%h data=%h want we=%b addr=%h", c, bus.fm_write_en, bus.fm_write_addr, bus.fm_write_data, p[c], 32'h20 + k);
      end
      if (p[c]) k++;
    end
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if (bus.done !== 1'b1 || bus.loaded_count !== 16'd3) begin
      n_fail++; $display("FAIL bub_run: got done=%b cnt=%0d want 1/3", bus.done, bus.loaded_count);
    end
  endtask

  task automatic test_zero;
    int w0;
    w0 = wr_cnt;
    do_start(16'd0);
    n_chk++;
    if (bus.fm_rst !== 1'b1 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL zero_clear: got fm_rst=%b busy=%b want 1/1", bus.fm_rst, bus.busy);
    end
    @(negedge clk);
    n_chk++;
    if (bus.fm_rst !== 1'b0 || bus.busy !== 1'b1 || bus.in_ready !== 1'b0 || bus.cpu_reset !== 1'b1) begin
      n_fail++; $display("FAIL zero_cpu_rst: got fm_rst=%b busy=%b ready=%b cpu_reset=%b want 0/1/0/1", bus.fm_rst, bus.busy, bus.in_ready, bus.cpu_reset);
    end
    @(negedge clk);
    n_chk++;
    if (bus.cpu_reset !== 1'b1 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL zero_hold: got cpu_reset=%b done=%b want 1/0", bus.cpu_reset, bus.done);
    end
    @(negedge clk);
    n_chk++;
    if (bus.done !== 1'b1 || bus.cpu_reset !== 1'b0 || bus.loaded_count !== 16'd0 || wr_cnt != w0) begin
      n_fail++; $display("FAIL zero_run: got done=%b cpu_reset=%b cnt=%0d writes=%0d want 1/0/0/0", bus.done, bus.cpu_reset, bus.loaded_count, wr_cnt - w0);
    end
  endtask

  task automatic test_oversize;
    do_start(16'd257);
    n_chk++;
    if (bus.err !== 1'b1 || bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.cpu_reset !== 1'b1) begin
      n_fail++; $display("FAIL over_reject: got err=%b done=%b busy=%b cpu_reset=%b want 1/0/0/1", bus.err, bus.done, bus.busy, bus.cpu_reset);
    end
    @(negedge clk);
    n_chk++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.err !== 1'b1 || bus.cpu_reset !== 1'b1) begin
      n_fail++; $display("FAIL over_idle: got busy=%b ready=%b err=%b cpu_reset=%b want 0/0/1/1", bus.busy, bus.in_ready, bus.err, bus.cpu_reset);
    end
  endtask

  task automatic test_max;
    int w0;
    int k;
    int cyc;
    w0 = wr_cnt;
    k = 0;
    cyc = 0;
    do_start(16'd256);
    n_chk++;
    if (bus.err !== 1'b0) begin n_fail++; $display("FAIL max_err_clear: got err=%b want 0", bus.err); end
    bus.in_valid = 1'b1;
    while (bus.done !== 1'b1 && cyc < 400) begin
      if (bus.in_ready === 1'b1) begin
        bus.in_data = 16'(k) ^ 16'h5A00;
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.in_valid = 1'b0;
    n_chk++;
    if (bus.done !== 1'b1) begin n_fail++; $display("FAIL max_timeout: got done=%b after %0d cycles want 1", bus.done, cyc); end
    n_chk++;
    if (last_addr !== 32'h11F || last_data !== 16'h5AFF) begin
      n_fail++; $display("FAIL max_last_write: got addr=%h data=%h want 11f/5aff", last_addr, last_data);
    end
    n_chk++;
    if (wr_cnt - w0 != 256 || bus.loaded_count !== 16'd256) begin
      n_fail++; $display("FAIL max_count: got writes=%0d cnt=%0d want 256/256", wr_cnt - w0, bus.loaded_count);
    end
  endtask

  task automatic test_abort;
    int w0;
    w0 = wr_cnt;
    do_start(16'd5);
    bus.in_valid = 1'b1;
    bus.in_data = 16'hA001;
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (bus.fm_write_en !== 1'b1 || bus.fm_write_addr !== 32'h20 || bus.fm_write_data !== 16'hA001) begin
      n_fail++; $display("FAIL abort_w0: got we=%b addr=%h data=%h want 1/20/a001", bus.fm_write_en, bus.fm_write_addr, bus.fm_write_data);
    end
    bus.in_data = 16'hA002;
    @(negedge clk);
    n_chk++;
    if (bus.fm_write_en !== 1'b1 || bus.fm_write_addr !== 32'h21 || bus.fm_write_data !== 16'hA002) begin
      n_fail++; $display("FAIL abort_w1: got we=%b addr=%h data=%h want 1/21/a002", bus.fm_write_en, bus.fm_write_addr, bus.fm_write_data);
    end
    bus.abort = 1'b1;
    bus.in_data = 16'hA003;
    @(negedge clk);
    bus.abort = 1'b0;
    bus.in_valid = 1'b0;
    n_chk++;
    if ({bus.fm_write_en, bus.err, bus.cpu_reset, bus.busy, bus.done, bus.in_ready} !== 6'b011000 || bus.loaded_count !== 16'd2) begin
      n_fail++;
      $display("FAIL abort_idle: got we/err/cpu_reset/busy/done/ready=%b cnt=%0d want 011000/2",
               {bus.fm_write_en, bus.err, bus.cpu_reset, bus.busy, bus.done, bus.in_ready}, bus.loaded_count);
    end
    repeat (2) @(negedge clk);
    n_chk++;
    if (wr_cnt - w0 != 2 || bus.err !== 1'b1) begin
      n_fail++; $display("FAIL abort_writes: got writes=%0d err=%b want 2/1", wr_cnt - w0, bus.err);
    end
    do_start(16'd0);
    n_chk++;
    if (bus.err !== 1'b0) begin n_fail++; $display("FAIL abort_err_clear: got err=%b want 0", bus.err); end
    repeat (3) @(negedge clk);
    n_chk++;
    if (bus.done !== 1'b1) begin n_fail++; $display("FAIL abort_rerun: got done=%b want 1", bus.done); end
  endtask

  task automatic test_reload;
    int w0;
    w0 = wr_cnt;
    do_start(16'd1);
    n_chk++;
    if (bus.cpu_reset !== 1'b1 || bus.done !== 1'b0 || bus.fm_rst !== 1'b1) begin
      n_fail++; $display("FAIL reload_start: got cpu_reset=%b done=%b fm_rst=%b want 1/0/1", bus.cpu_reset, bus.done, bus.fm_rst);
    end
    bus.in_valid = 1'b1;
    bus.in_data = 16'h2BBF;
    @(negedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_chk++;
    if (bus.fm_write_en !== 1'b1 || bus.fm_write_addr !== 32'h20 || bus.fm_write_data !== 16'h2BBF || bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL reload_write: got we=%b addr=%h data=%h ready=%b want 1/20/2bbf/0", bus.fm_write_en, bus.fm_write_addr, bus.fm_write_data, bus.in_ready);
    end
    repeat (2) @(negedge clk);
    n_chk++;
    if (bus.done !== 1'b1 || bus.cpu_reset !== 1'b0 || bus.loaded_count !== 16'd1 || wr_cnt - w0 != 1) begin
      n_fail++; $display("FAIL reload_run: got done=%b cpu_reset=%b cnt=%0d writes=%0d want 1/0/1/1", bus.done, bus.cpu_reset, bus.loaded_count, wr_cnt - w0);
    end
  endtask

  task automatic test_async_reset;
    int w0;
    do_start(16'd4);
    bus.in_valid = 1'b1;
    bus.in_data = 16'hC000;
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (bus.fm_write_en !== 1'b1) begin n_fail++; $display("FAIL arst_pre_write: got we=%b want 1", bus.fm_write_en); end
    #2;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    n_chk++;
    if ({bus.cpu_reset, bus.fm_write_en, bus.in_ready, bus.busy, bus.done, bus.fm_rst} !== 6'b100000) begin
      n_fail++; $display("FAIL arst_flags: got cpu_reset/we/ready/busy/done/fm_rst=%b want 100000",
                         {bus.cpu_reset, bus.fm_write_en, bus.in_ready, bus.busy, bus.done, bus.fm_rst});
    end
    n_chk++;
    if (bus.fm_write_addr !== 32'h20 || bus.loaded_count !== 16'd0) begin
      n_fail++; $display("FAIL arst_regs: got addr=%h cnt=%0d want 20/0", bus.fm_write_addr, bus.loaded_count);
    end
    w0 = wr_cnt;
    repeat (2) @(negedge clk);
    n_chk++;
    if (wr_cnt != w0 || bus.fm_write_en !== 1'b0) begin
      n_fail++; $display("FAIL arst_no_write: got writes=%0d we=%b want 0/0", wr_cnt - w0, bus.fm_write_en);
    end
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_normal();
    test_bubbles();
    test_zero();
    test_oversize();
    test_max();
    test_abort();
    test_reload();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/prog_load_ctrl.md
Name: prog_load_ctrl

Overview:
- Boot/program-load sequencer for the pipelined processor.
- Holds the processor in reset, clears the instruction memory, and streams instruction words into it over a valid/ready handshake. Words go to consecutive addresses from BASE_ADDR.
- After loading, pulses the processor reset and releases the processor to run.
- Sits between the host/load interface and the processor's instruction-memory write port (fm_*) and reset input.

Parameters:
ADDR_W, 32, instruction-memory address width
DATA_W, 16, instruction word width
BASE_ADDR, 32'h20, address of the first loaded word
CLR_CYCLES, 1, cycles fm_rst is held high in CLEAR (>=1)
RST_CYCLES, 2, cycles of the final processor-reset pulse in CPU_RST (>=1)
MAX_WORDS, 256, largest legal word_count

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  single-cycle load request, sampled in IDLE or RUN
word_count  in  16  number of words to load, captured on accepted start
in_valid  in  1  in_data holds a word
in_data  in  DATA_W  instruction word
in_ready  out  1  controller accepts a word this cycle
abort  in  1  cancel the load in progress
fm_rst  out  1  instruction-memory clear, active-high
fm_write_en  out  1  instruction-memory write strobe
fm_write_addr  out  ADDR_W  write address
fm_write_data  out  DATA_W  write data
cpu_reset  out  1  processor reset, active-high
busy  out  1  high in CLEAR, LOAD or CPU_RST
done  out  1  high in RUN
loaded_count  out  16  words written in the current/last load
err  out  1  sticky error flag, cleared on the next accepted start

Behaviour:
- Reset (reset=0, asynchronous):
  - State becomes IDLE.
  - cpu_reset=1: the processor is held until a program is loaded.
  - All other outputs are 0; fm_write_addr=BASE_ADDR.
- States: IDLE, CLEAR, LOAD, CPU_RST, RUN. All outputs are registered.
- IDLE / RUN + start:
  - If word_count>MAX_WORDS: set err=1 and go to IDLE; from RUN, cpu_reset is asserted on entry.
  - Otherwise: capture word_count, clear err and loaded_count, set cpu_reset=1, go to CLEAR.
- CLEAR:
  - fm_rst=1 for exactly CLR_CYCLES cycles, then fm_rst returns to 0.
  - If the captured count is 0, go to CPU_RST; otherwise go to LOAD.
- LOAD:
  - in_ready=1 on every cycle in LOAD and 0 in all other states.
  - A handshake (in_valid & in_ready) at edge t produces, in the cycle after edge t:
    - fm_write_en=1, single cycle
    - fm_write_data=in_data
    - fm_write_addr=BASE_ADDR+index, with index starting at 0
    - loaded_count incremented
  - Back-to-back handshakes give back-to-back writes, one word per cycle.
  - in_valid=0 inserts bubbles; the index does not advance.
  - The handshake for the last word moves to CPU_RST on the same edge. in_ready drops in CPU_RST, so no extra word is accepted.
- CPU_RST:
  - cpu_reset stays 1 for RST_CYCLES more cycles.
  - Then go to RUN with cpu_reset=0 and done=1.
- RUN:
  - Hold until start. A new start asserts cpu_reset and drops done on the next edge.
- abort in CLEAR or LOAD:
  - Next state is IDLE with err=1 and cpu_reset kept at 1.
  - A write from the final handshake still completes.
  - fm_rst drops.
- abort in IDLE, CPU_RST or RUN is ignored.
- abort and a handshake in the same cycle: abort wins, and the word is not written.
- start outside IDLE/RUN is ignored.
- Address arithmetic is modulo 2^ADDR_W; wrap-around is permitted.
- Asserting reset mid-load returns to IDLE immediately, with no further writes.

Test Plan:
- Normal load, word_count=4, words 0x453F, 0x653F, 0x8C3D, 0xBBBF, in_valid held high:
  - fm_rst pulses 1 cycle.
  - Writes go to 0x20..0x23 on 4 consecutive cycles.
  - cpu_reset falls exactly 2 cycles after the last write cycle's entry into CPU_RST.
  - done=1, loaded_count=4.
- Bubbled stream, word_count=3, in_valid toggling 1,0,1,0,1: three writes to 0x20, 0x21, 0x22, each one cycle after its handshake; no write in bubble cycles.
- Boundary counts:
  - word_count=0: CLEAR, then CPU_RST, then RUN, with no fm_write_en pulses.
  - word_count=257: err=1, stays IDLE, cpu_reset=1.
  - word_count=256: final write at 0x11F.
- Abort: word_count=5, assert abort after the 2nd handshake. Exactly 2 writes occur, state goes to IDLE, err=1, cpu_reset stays 1. A subsequent valid start clears err.
- Reload from RUN: start with word_count=1, data 0x2BBF. cpu_reset rises the next cycle, a single write goes to 0x20, then RUN is re-entered.
- Asynchronous reset asserted mid-LOAD, between clock edges: outputs go to reset values immediately, including cpu_reset=1, fm_write_en=0 and in_ready=0.
